demo_input_player: RTL
======================

// Module: demo_input_player
// PURPOSE
//  Attract-mode keycode source feeding the player movement block's 8-bit keycode input.
//  Passes live keyboard keycodes through, registered.
//  After IDLE_FRAMES idle frames it plays a scripted table of {keycode, duration} entries.
//  Any live key or enable low aborts playback at once.
//  Sits between the USB keycode register and the player block; one update per frame_clk edge.
// PARAMETERS
//  IDLE_FRAMES  600  consecutive idle frames before playback starts (10 s at 60 Hz)
//  SCRIPT_LEN   8    script table depth (entries)
//  DUR_W        8    width of per-entry duration field (frames)
// PORTS
//  frame_clk   in   1                    frame clock, one edge per video frame
//  Reset       in   1                    synchronous, active-high
//  enable      in   1                    1 = attract mode permitted
//  key_in      in   8                    live keyboard keycode, 8'h00 = no key
//  keycode     out  8                    keycode to player block (registered)
//  demo_active out  1                    1 while scripted keycodes are driven
//  step_idx    out  $clog2(SCRIPT_LEN)   current script entry
//  demo_done   out  1                    1-frame pulse at natural end of script
// BEHAVIOUR
//  Reset values:
//   - keycode=8'h00, demo_active=0, step_idx=0, demo_done=0
//   - state=WAIT, idle_cnt=0, dur_cnt=0
//  Script table (internal constant), keys W=1A S=16 A=04 D=07:
//   - 0:{07,40}  1:{1A,70}  2:{04,30}  3:{00,20}
//   - 4+: {00,0}; duration 0 = terminator
//  All outputs are registered: key_in -> keycode latency is 1 frame.
//  State WAIT:
//   - keycode<=key_in.
//   - idle_cnt increments when key_in==0 && enable; clears otherwise; saturates.
//   - Go to PLAY when idle_cnt==IDLE_FRAMES-1 && key_in==0 && enable.
//   - On that edge: keycode<=entry0.key, dur_cnt<=entry0.dur, step_idx<=0, demo_active<=1.
//  State PLAY, per edge, in priority order:
//   1. Abort: key_in!=0 || !enable.
//      -> WAIT, keycode<=key_in, demo_active<=0, idle_cnt<=0, no demo_done.
//   2. dur_cnt>1: dur_cnt<=dur_cnt-1.
//   3. dur_cnt==1: load the next entry (key, dur, step_idx+1).
//  End of script: the next entry is a terminator, or step_idx==SCRIPT_LEN-1.
//   -> see CONFIGURATION.
//  Each entry is held on keycode for exactly dur frames.
//  An entry0 with dur==0 means the start condition is ignored (stay in WAIT).
//  Simultaneous key_in!=0 on the threshold edge: stay in WAIT, idle_cnt<=0.
//  Reset mid-PLAY returns all state to reset values on that edge.
//  Arithmetic is unsigned. idle_cnt is wide enough to hold IDLE_FRAMES. No wrap.
// CONFIGURATION
//  Macro DEMO_LOOP_EN.
//  Defined:
//   - End of script reloads entry0 (step_idx<=0, keycode<=entry0.key, dur_cnt<=entry0.dur).
//   - demo_done pulses 1 frame, demo_active stays 1.
//  Undefined:
//   - End of script goes to WAIT.
//   - keycode<=key_in (8'h00), demo_active<=0, idle_cnt<=0, demo_done pulses 1 frame.
// TESTING
//  1. Reset=1 for 2 frames, key_in=1A -> keycode=00, demo_active=0, step_idx=0, demo_done=0.
//  2. After reset, key_in=00, enable=1:
//     - edges 1..599: keycode=00.
//     - edge 600: keycode=07, demo_active=1.
//     - edge 640: keycode=1A. Edge 710: keycode=04. Edge 740: keycode=00 (step 3).
//  3. Continue scenario 2 (no loop): edge 760: demo_done=1, demo_active=0, keycode=00.
//     Next demo start at edge 1360.
//     With DEMO_LOOP_EN: edge 760: keycode=07, step_idx=0, demo_done=1, demo_active=1.
//  4. Playing at step 1, key_in=04 for 1 frame:
//     - next edge: keycode=04, demo_active=0, demo_done=0.
//     - playback restarts 600 idle frames later at entry0.
//  5. Playing, enable=0 -> next edge: demo_active=0. While enable=0, no restart after >600 frames.
//  6. Edge cases:
//     - key_in=16 on the threshold edge (idle_cnt=599): stays WAIT, keycode=16.
//     - Reset asserted mid-entry 2: keycode=00 on the next edge.

Source files
------------

// File: rtl/demo_input_player.sv
// demo_input_player
//   Attract-mode keycode source placed between the USB keycode register and
//   the player movement block. Live keycodes pass through with one frame of
//   latency. After IDLE_FRAMES consecutive idle frames, a scripted table of
//   {keycode, duration} entries is played. Any live key, or enable going low,
//   aborts playback on the same edge.
//
//   Optional build macro: DEMO_LOOP_EN
//     defined   : the script loops back to entry 0 at its end, and demo_active stays high
//     undefined : the script returns to pass-through at its end
//
// Ports
//   frame_clk    in   frame clock, one edge per video frame
//   Reset        in   synchronous, active-high reset
//   enable       in   1 = attract mode permitted
//   key_in       in   [7:0] live keycode, 8'h00 = no key
//   keycode      out  [7:0] registered keycode to the player block
//   demo_active  out  1 while scripted keycodes are driven
//   step_idx     out  current script entry
//   demo_done    out  1-frame pulse at the natural end of the script
//
// state  | meaning
// S_WAIT | pass key_in through, count idle frames
// S_PLAY | drive scripted keycodes, count down the entry duration

module demo_input_player #(
  parameter int IDLE_FRAMES = 600,
  parameter int SCRIPT_LEN  = 8,
  parameter int DUR_W       = 8,
  localparam int SW = (SCRIPT_LEN > 1) ? $clog2(SCRIPT_LEN) : 1,
  localparam int IW = $clog2(IDLE_FRAMES + 1)
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic          enable,
  input  logic [7:0]    key_in,
  output logic [7:0]    keycode,
  output logic          demo_active,
  output logic [SW-1:0] step_idx,
  output logic          demo_done
);

  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  logic [0:0]       state;
  logic [IW-1:0]    idle_cnt;
  logic [DUR_W-1:0] dur_cnt;

  // Script entry: {keycode, duration}. Duration 0 terminates the script.
  function automatic logic [8+DUR_W-1:0] entry(input logic [SW-1:0] idx);
    case (int'(idx))
      0:       entry = {8'h07, DUR_W'(40)};
      1:       entry = {8'h1A, DUR_W'(70)};
      2:       entry = {8'h04, DUR_W'(30)};
      3:       entry = {8'h00, DUR_W'(20)};
      default: entry = {8'h00, DUR_W'(0)};
    endcase
  endfunction

  logic             idle;
  logic [SW-1:0]    next_idx;
  logic [7:0]       e0_key;
  logic [DUR_W-1:0] e0_dur;
  logic [7:0]       nx_key;
  logic [DUR_W-1:0] nx_dur;
  logic             last;

  always_comb begin
    idle             = (key_in == 8'h00) && enable;
    next_idx         = step_idx + 1'b1;
    {e0_key, e0_dur} = entry('0);
    {nx_key, nx_dur} = entry(next_idx);
    // The last table slot ends the script even without a terminator entry.
    last             = (step_idx == SW'(SCRIPT_LEN - 1)) || (nx_dur == '0);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state       <= S_WAIT;
      idle_cnt    <= '0;
      dur_cnt     <= '0;
      keycode     <= 8'h00;
      demo_active <= 1'b0;
      step_idx    <= '0;
      demo_done   <= 1'b0;
    end else begin
      demo_done <= 1'b0;
      case (state)
        S_WAIT: begin
          keycode <= key_in;
          if (idle) begin
            if (idle_cnt != IW'(IDLE_FRAMES))
              idle_cnt <= idle_cnt + 1'b1;
            // An empty script (entry 0 duration 0) never starts.
            if (idle_cnt == IW'(IDLE_FRAMES - 1) && e0_dur != '0) begin
              state       <= S_PLAY;
              keycode     <= e0_key;
              dur_cnt     <= e0_dur;
              step_idx    <= '0;
              demo_active <= 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        S_PLAY: begin
          if (!idle) begin
            state       <= S_WAIT;
            keycode     <= key_in;
            demo_active <= 1'b0;
            idle_cnt    <= '0;
          end else if (dur_cnt > DUR_W'(1)) begin
            dur_cnt <= dur_cnt - 1'b1;
          end else if (last) begin
            demo_done <= 1'b1;
`ifdef DEMO_LOOP_EN
            step_idx <= '0;
            keycode  <= e0_key;
            dur_cnt  <= e0_dur;
`else
            state       <= S_WAIT;
            keycode     <= key_in;
            demo_active <= 1'b0;
            idle_cnt    <= '0;
`endif
          end else begin
            step_idx <= next_idx;
            keycode  <= nx_key;
            dur_cnt  <= nx_dur;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
